riscv_zero_imem_loader: RTL and testbench

//  Program loader: the writer side of the instruction RAM that riscv_zero_fetch reads.

---
 rtl/riscv_zero_imem_loader_pkg.sv | 23 ++
 rtl/riscv_zero_imem_loader_if.sv | 24 ++
 rtl/riscv_zero_imem_loader_word_assembler.sv | 37 +++
 rtl/riscv_zero_imem_loader.sv | 98 +++++++++
 tb/tb_riscv_zero_imem_loader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_zero_imem_loader_pkg.sv
// Shared types and constants for the instruction-RAM program loader.
package riscv_zero_imem_loader_pkg;

   localparam int XLEN           = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef logic [XLEN-1:0] word_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   // A length header is usable when it is non-zero and fits in the RAM.
   function automatic logic len_ok(input word_t n, input int unsigned max_words);
      return (n != '0) && (n <= word_t'(max_words));
   endfunction

endpackage

// File: rtl/riscv_zero_imem_loader_if.sv
// Byte-stream input and RAM write port of the loader, bundled as one bus.
interface riscv_zero_imem_loader_if;
   import riscv_zero_imem_loader_pkg::*;

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic       mem_we;
   word_t      mem_addr;
   word_t      mem_wdata;

   // The loader consumes the stream and drives the RAM port.
   modport master (
      input  byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );

   // The environment sources bytes and observes the RAM port.
   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/riscv_zero_imem_loader_word_assembler.sv
// Packs accepted stream bytes into little-endian 32-bit words.
// Used for both the length header and the data words.
module riscv_zero_word_assembler
   import riscv_zero_imem_loader_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       accept,
   input  logic [7:0] byte_in,
   output logic       word_valid,
   output word_t      word
);

   logic [1:0]      byte_cnt;
   logic [XLEN-9:0] lower;    // the three earlier bytes of the current word

   // Count accepted bytes and shift each one in from the top, so byte 0 ends at bits [7:0].
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: registers take <= so every flop samples pre-edge values regardless of statement order.
      if (!reset) begin
         byte_cnt <= '0;
         lower    <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
         lower    <= '0;
      end else if (accept) begin
         byte_cnt <= byte_cnt + 2'd1;
         lower    <= {byte_in, lower[XLEN-9:8]};
      end
   end

   // The completed word is available combinationally in the cycle its last byte is accepted.
   assign word       = {byte_in, lower};
   assign word_valid = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/riscv_zero_imem_loader.sv
// Program loader: length-prefixed byte stream -> instruction RAM writes.
// Keeps the core held in reset until the whole image has been written.
module riscv_zero_imem_loader
   import riscv_zero_imem_loader_pkg::*;
#(
   parameter word_t       BASE_ADDR = 32'h0,
   parameter int unsigned MEM_WORDS = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   riscv_zero_imem_loader_if.master  bus,
   output logic                      core_hold,
   output logic                      done,
   output logic                      error,
   output word_t                     words_loaded
);

   state_t state, state_nxt;
   word_t  n_words;
   word_t  word;
   logic   word_valid;
   logic   accept;

   assign accept = bus.byte_valid && bus.byte_ready;

   riscv_zero_word_assembler u_assembler (
      .clk        (clk),
      .reset      (reset),
      .clear      (start),
      .accept     (accept),
      .byte_in    (bus.byte_data),
      .word_valid (word_valid),
      .word       (word)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; start re-arms the loader from any state.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      if (start) begin
         state_nxt = S_LEN;
      end else begin
         case (state)
            S_LEN:   if (word_valid) state_nxt = len_ok(word, MEM_WORDS) ? S_DATA : S_ERR;
            S_DATA:  if (word_valid) state_nxt = S_WRITE;
            S_WRITE: state_nxt = (words_loaded + 32'd1 == n_words) ? S_DONE : S_DATA;
            default: state_nxt = state;
         endcase
      end
   end

   // Outputs decoded from state; start suppresses byte intake and drops a pending write.
   always_comb begin
      bus.byte_ready = 1'b0;
      bus.mem_we     = 1'b0;
      core_hold      = 1'b1;
      done           = 1'b0;
      error          = 1'b0;
      case (state)
         S_LEN, S_DATA: bus.byte_ready = !start;
         S_WRITE:       bus.mem_we     = !start;
         S_DONE: begin
            core_hold = 1'b0;
            done      = 1'b1;
         end
         S_ERR:         error = 1'b1;
         default:       ;
      endcase
   end

   // Length, progress count and RAM address/data registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_words       <= '0;
         words_loaded  <= '0;
         bus.mem_addr  <= BASE_ADDR;
         bus.mem_wdata <= '0;
      end else if (start) begin
         n_words      <= '0;
         words_loaded <= '0;
      end else begin
         if (state == S_LEN && word_valid) n_words <= word;
         if (state == S_DATA && word_valid) begin
            bus.mem_wdata <= word;
            bus.mem_addr  <= BASE_ADDR + (words_loaded << 2);
         end
         if (state == S_WRITE) words_loaded <= words_loaded + 32'd1;
      end
   end

endmodule

// File: tb/tb_riscv_zero_imem_loader.sv
// Self-checking bench for riscv_zero_imem_loader: randomized images against a
// stream-level model (header -> expected word list at BASE + 4*i).
`timescale 1ns/1ps
module tb_riscv_zero_imem_loader;
   import riscv_zero_imem_loader_pkg::*;

   localparam int unsigned A_WORDS = 16;
   localparam logic [31:0] B_BASE  = 32'h1C;

   typedef logic [31:0] wq_t[$];
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        sel_b = 1'b0;
   logic        core_hold_a, done_a, error_a;
   logic        core_hold_b, done_b, error_b;
   logic [31:0] words_a, words_b;

   int checks = 0;
   int errors = 0;

   wr_t         wr_a[$];
   wr_t         wr_b[$];
   logic [31:0] ram_b [logic [31:0]];

   riscv_zero_imem_loader_if bus_a();
   riscv_zero_imem_loader_if bus_b();

   assign bus_a.byte_valid = byte_valid;
   assign bus_a.byte_data  = byte_data;
   assign bus_b.byte_valid = byte_valid;
   assign bus_b.byte_data  = byte_data;

   riscv_zero_imem_loader #(.BASE_ADDR(32'h0), .MEM_WORDS(A_WORDS)) dut_a (
      .clk          (clk),
      .reset        (reset),
      .start        (start_a),
      .bus          (bus_a),
      .core_hold    (core_hold_a),
      .done         (done_a),
      .error        (error_a),
      .words_loaded (words_a)
   );

   riscv_zero_imem_loader #(.BASE_ADDR(B_BASE)) dut_b (
      .clk          (clk),
      .reset        (reset),
      .start        (start_b),
      .bus          (bus_b),
      .core_hold    (core_hold_b),
      .done         (done_b),
      .error        (error_b),
      .words_loaded (words_b)
   );

   always #5 clk = ~clk;

   // Record every RAM write; B also feeds a small RAM that a fetch reads back.
   always @(negedge clk) begin
      if (bus_a.mem_we === 1'b1) wr_a.push_back('{bus_a.mem_addr, bus_a.mem_wdata});
      if (bus_b.mem_we === 1'b1) begin
         wr_b.push_back('{bus_b.mem_addr, bus_b.mem_wdata});
         ram_b[bus_b.mem_addr] = bus_b.mem_wdata;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic cur_ready();
      return sel_b ? bus_b.byte_ready : bus_a.byte_ready;
   endfunction

   function automatic wq_t rand_words(input int n);
      wq_t q;
      for (int i = 0; i < n; i++) q.push_back($urandom);
      return q;
   endfunction

   // Offer one byte after `stall` idle cycles; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b, input int stall, input bit chk_ready);
      logic rdy;
      logic got;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         byte_valid = 1'b0;
         if (chk_ready) check("ready_while_stalled", 32'(cur_ready()), 32'd1);
      end
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         rdy = cur_ready();
         @(posedge clk);
         if (rdy) got = 1'b1;
         else     @(negedge clk);
      end
      #1 byte_valid = 1'b0;
      check("byte_accepted", 32'(got), 32'd1);
   endtask

   task automatic send_bytes(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_byte(bytes[i], 0, 1'b0);
   endtask

   task automatic pulse_start_a();
      @(negedge clk);
      start_a = 1'b1;
      #1 check("ready_in_start_cycle", 32'(bus_a.byte_ready), 32'd0);
      @(negedge clk);
      start_a = 1'b0;
   endtask

   // Stream an image into A (already armed) and compare against the model.
   task automatic run_load(input string tag, input logic [31:0] n, input wq_t words,
                           input int stall_max, input int stall_at);
      logic [7:0] bytes[$];
      bit ok;
      ok = (n != 0) && (n <= A_WORDS);
      for (int j = 0; j < 4; j++) bytes.push_back(8'((n >> (8 * j)) & 32'hFF));
      if (ok) foreach (words[i]) for (int j = 0; j < 4; j++)
         bytes.push_back(8'((words[i] >> (8 * j)) & 32'hFF));
      foreach (bytes[i])
         send_byte(bytes[i], (i == stall_at) ? 3 : int'($urandom_range(0, stall_max)), i == stall_at);
      repeat (3) @(negedge clk);
      if (ok) begin
         check({tag, "_done"}, 32'(done_a), 32'd1);
         check({tag, "_core_hold"}, 32'(core_hold_a), 32'd0);
         check({tag, "_error"}, 32'(error_a), 32'd0);
         check({tag, "_words_loaded"}, words_a, n);
         check({tag, "_num_writes"}, 32'(wr_a.size()), n);
         for (int i = 0; i < wr_a.size() && i < int'(n); i++) begin
            check({tag, "_addr"}, wr_a[i].addr, 32'(4 * i));
            check({tag, "_data"}, wr_a[i].data, words[i]);
         end
      end else begin
         check({tag, "_error"}, 32'(error_a), 32'd1);
         check({tag, "_done"}, 32'(done_a), 32'd0);
         check({tag, "_core_hold"}, 32'(core_hold_a), 32'd1);
         check({tag, "_num_writes"}, 32'(wr_a.size()), 32'd0);
         check({tag, "_ready"}, 32'(bus_a.byte_ready), 32'd0);
      end
   endtask

   task automatic load_a(input string tag, input logic [31:0] n, input wq_t words,
                         input int stall_max, input int stall_at);
      wr_a.delete();
      pulse_start_a();
      run_load(tag, n, words, stall_max, stall_at);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, 32'(bus_a.byte_ready), 32'd0);
      check({tag, "_mem_we"}, 32'(bus_a.mem_we), 32'd0);
      check({tag, "_mem_addr"}, bus_a.mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, bus_a.mem_wdata, 32'h0);
      check({tag, "_core_hold"}, 32'(core_hold_a), 32'd1);
      check({tag, "_done"}, 32'(done_a), 32'd0);
      check({tag, "_error"}, 32'(error_a), 32'd0);
      check({tag, "_words_loaded"}, words_a, 32'd0);
   endtask

   initial begin
      wq_t w;
      logic [7:0] hdr[$];

      // Reset values
      #12;
      check_reset_values("reset");
      check("reset_b_addr", bus_b.mem_addr, B_BASE);
      @(negedge clk);
      reset = 1'b1;

      // Directed two-word image, then the same image with a 3-cycle mid-word stall
      w = '{32'hABCD1234, 32'hABCD5678};
      load_a("basic", 32'd2, w, 0, -1);
      load_a("stall", 32'd2, w, 0, 6);

      // Length header boundaries
      w = {};
      load_a("len_zero", 32'd0, w, 0, -1);
      load_a("len_over", A_WORDS + 1, w, 0, -1);
      load_a("len_max", A_WORDS, rand_words(A_WORDS), 1, -1);

      // Random images with random stalls
      for (int k = 0; k < 6; k++) begin
         int n;
         n = int'($urandom_range(1, A_WORDS));
         load_a("random", 32'(n), rand_words(n), 2, -1);
      end

      // Restart after two bytes of the first data word: header is re-read, old bytes dropped
      wr_a.delete();
      pulse_start_a();
      hdr = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
      send_bytes(hdr);
      pulse_start_a();
      check("restart_words_loaded", words_a, 32'd0);
      run_load("restart", 32'd2, rand_words(2), 1, -1);

      // Start while in S_WRITE drops the pending write
      wr_a.delete();
      pulse_start_a();
      hdr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      send_bytes(hdr);
      #1 start_a = 1'b1;
      @(negedge clk);
      check("start_in_write_mem_we", 32'(bus_a.mem_we), 32'd0);
      @(posedge clk);
      #1 start_a = 1'b0;
      @(negedge clk);
      check("start_in_write_ready", 32'(bus_a.byte_ready), 32'd1);
      check("start_in_write_no_write", 32'(wr_a.size()), 32'd0);
      run_load("after_drop", 32'd2, rand_words(2), 1, -1);

      // Asynchronous reset while in S_WRITE
      wr_a.delete();
      pulse_start_a();
      hdr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
      send_bytes(hdr);
      #1 reset = 1'b0;
      #1 check_reset_values("mid_write_reset");
      @(negedge clk);
      check("mid_write_no_write", 32'(wr_a.size()), 32'd0);
      reset = 1'b1;
      load_a("post_reset", 32'd3, rand_words(3), 1, -1);

      // Second loader at BASE 0x1C; then a fetch from 0x1C
      sel_b = 1'b1;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      hdr = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hDA, 8'hB1, 8'hCA};
      send_bytes(hdr);
      repeat (3) @(negedge clk);
      check("base_num_writes", 32'(wr_b.size()), 32'd1);
      if (wr_b.size() > 0) begin
         check("base_addr", wr_b[0].addr, B_BASE);
         check("base_data", wr_b[0].data, 32'hCAB1DAB1);
      end
      check("base_done", 32'(done_b), 32'd1);
      check("base_core_hold", 32'(core_hold_b), 32'd0);
      check("base_words_loaded", words_b, 32'd1);
      check("fetch_present", 32'(ram_b.exists(B_BASE)), 32'd1);
      if (ram_b.exists(B_BASE)) check("fetch_data", ram_b[B_BASE], 32'hCAB1DAB1);
      check("a_still_done", 32'(done_a), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
